dmem_arbiter: RTL and testbench

- Shares the single-port 64-word data memory between the pipeline MEM stage and a DMA/loader requester.
- The pipeline has default priority. A starvation counter forces a one-cycle DMA steal, which stalls the MEM stage.
- Sits between the MEM-stage signals (ALUOutM, WriteDataM, memory write enable) and the data memory.
- Adds out-of-range address protection.

---
 rtl/dmem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the pipeline MEM stage and a
//   DMA/loader requester. The pipeline normally has priority. A DMA request
//   that keeps being refused ages a wait counter. When the counter reaches
//   MAX_WAIT, the arbiter spends one FORCE cycle that grants the DMA and
//   stalls the MEM stage. Accesses outside 0..DEPTH-1 are blocked: writes are
//   dropped, reads return zero, and a sticky error flag is raised.
//
// Ports
//   CLK, rst                     clock (rising edge), async active-high reset
//   MemReqM, MemWriteM           MEM-stage access request / store select
//   ALUOutM, WriteDataM          MEM-stage word address / store data
//   ReadDataM                    MEM-stage load data (combinational)
//   StallM                       MEM stage must hold its request this cycle
//   dma_req, dma_we              DMA request (held until granted) / write select
//   dma_addr, dma_wdata          DMA word address / write data
//   dma_gnt                      DMA access performed this cycle (combinational)
//   dma_rdata, dma_rvalid        registered DMA read data / one-cycle valid
//   err_clr, addr_err            clear / sticky out-of-range flag
//   mem_we, mem_addr, mem_wdata  memory write enable / address / write data
//   mem_rdata                    memory asynchronous read data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    input  logic        err_clr,
    output logic        addr_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0]      DEPTH_W = 32'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]      dma_rdata_q, dma_rdata_d;
    logic             dma_rvalid_q, dma_rvalid_d;
    logic             addr_err_q, addr_err_d;

    logic             pipe_own_s;
    logic             dma_own_s;
    logic             pipe_ok_s;
    logic             dma_ok_s;
    logic             bad_access_s;

    // Word address lies inside the physical memory.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr < DEPTH_W);
    endfunction

    assign pipe_ok_s = in_range(ALUOutM);
    assign dma_ok_s  = in_range(dma_addr);

    // Owner selection: FORCE reserves the cycle for the DMA; otherwise the pipeline wins.
    always_comb begin
        pipe_own_s = 1'b0;
        dma_own_s  = 1'b0;
        case (state_q)
            ST_FORCE: begin
                dma_own_s = dma_req;
            end
            ST_NORMAL: begin
                if (MemReqM) begin
                    pipe_own_s = 1'b1;
                end else begin
                    dma_own_s = dma_req;
                end
            end
            default: begin
                pipe_own_s = 1'b0;
                dma_own_s  = 1'b0;
            end
        endcase
    end

    // Memory port drive; with no owner the pipeline fields pass through with writes disabled.
    always_comb begin
        mem_addr  = ALUOutM;
        mem_wdata = WriteDataM;
        mem_we    = 1'b0;
        if (dma_own_s) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we && dma_ok_s;
        end else if (pipe_own_s) begin
            mem_we    = MemWriteM && pipe_ok_s;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Pipeline load data, zeroed when the pipeline does not own or the address is illegal.
    always_comb begin
        if (pipe_own_s && pipe_ok_s) begin
            ReadDataM = mem_rdata;
        end else begin
            ReadDataM = 32'h0000_0000;
        end
    end

    assign dma_gnt = dma_own_s;
    assign StallM  = (state_q == ST_FORCE) && MemReqM;

    // An out-of-range address counts only when its requester actually owns the memory.
    assign bad_access_s = (pipe_own_s && !pipe_ok_s) || (dma_own_s && !dma_ok_s);

    // Next-state computation for the FSM, wait counter, DMA read return and error flag.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dma_rdata_d  = dma_rdata_q;
        dma_rvalid_d = 1'b0;
        addr_err_d   = addr_err_q;

        // Wait counter ages only while a request is pending and refused.
        if (dma_own_s || !dma_req) begin
            wait_cnt_d = {CNT_W{1'b0}};
        end else if (wait_cnt_q < MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        case (state_q)
            ST_NORMAL: begin
                if (wait_cnt_d == MAX_CNT) begin
                    state_d = ST_FORCE;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_FORCE: begin
                // FORCE lasts exactly one cycle, granted or not.
                state_d    = ST_NORMAL;
                wait_cnt_d = {CNT_W{1'b0}};
            end
            default: begin
                state_d    = ST_NORMAL;
                wait_cnt_d = {CNT_W{1'b0}};
            end
        endcase

        if (dma_own_s && !dma_we) begin
            dma_rdata_d  = dma_ok_s ? mem_rdata : 32'h0000_0000;
            dma_rvalid_d = 1'b1;
        end else begin
            dma_rvalid_d = 1'b0;
        end

        // A new bad access wins over a simultaneous clear.
        if (bad_access_s) begin
            addr_err_d = 1'b1;
        end else if (err_clr) begin
            addr_err_d = 1'b0;
        end else begin
            addr_err_d = addr_err_q;
        end
    end

    // State and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q      <= ST_NORMAL;
            wait_cnt_q   <= {CNT_W{1'b0}};
            dma_rdata_q  <= 32'h0000_0000;
            dma_rvalid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. It includes a 64-word memory model with
//   asynchronous read and synchronous write. Inputs change just after the
//   falling edge. Combinational outputs are sampled 1 ns later, and registered
//   outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        CLK;
    logic        rst;
    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic [31:0] dma_rdata;
    logic        dma_rvalid;
    logic        err_clr;
    logic        addr_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(
        .DEPTH    (64),
        .MAX_WAIT (4),
        .CNT_W    (3)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .err_clr    (err_clr),
        .addr_err   (addr_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory model: asynchronous read, write on the rising edge.
    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0000_00A0;   // aliased by address 64
        mem[6]  = 32'h0000_0066;   // aliased by address 70
        mem[36] = 32'h0000_0036;   // aliased by address 100
        rst = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; ALUOutM = 32'h0; WriteDataM = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; err_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk1 ("rst_rvalid", dma_rvalid, 1'b0);
        chk32("rst_rdata",  dma_rdata,  32'h0);
        chk1 ("rst_err",    addr_err,   1'b0);
        @(negedge CLK); rst = 1'b0; #1;
        chk1 ("idle_stall", StallM,    1'b0);
        chk1 ("idle_gnt",   dma_gnt,   1'b0);
        chk1 ("idle_we",    mem_we,    1'b0);
        chk32("idle_rd",    ReadDataM, 32'h0);
        @(posedge CLK); #1;
        chk1 ("idle_rvalid", dma_rvalid, 1'b0);
        chk1 ("idle_err",    addr_err,   1'b0);

        // Pipeline store then load of address 5
        @(negedge CLK); MemReqM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'd5; WriteDataM = 32'hDEADBEEF; #1;
        chk1 ("st_we",    mem_we,    1'b1);
        chk32("st_addr",  mem_addr,  32'd5);
        chk32("st_wdata", mem_wdata, 32'hDEADBEEF);
        chk1 ("st_stall", StallM,    1'b0);
        chk1 ("st_gnt",   dma_gnt,   1'b0);
        @(negedge CLK); MemWriteM = 1'b0; WriteDataM = 32'h0; #1;
        chk32("ld_rd", ReadDataM, 32'hDEADBEEF);
        chk1 ("ld_we", mem_we,    1'b0);

        // DMA read of address 5 with the pipeline idle
        @(negedge CLK); MemReqM = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd5; #1;
        chk1 ("dr_gnt",   dma_gnt,   1'b1);
        chk32("dr_addr",  mem_addr,  32'd5);
        chk32("dr_pipe",  ReadDataM, 32'h0);
        chk1 ("dr_stall", StallM,    1'b0);
        @(posedge CLK); #1;
        chk1 ("dr_rvalid", dma_rvalid, 1'b1);
        chk32("dr_rdata",  dma_rdata,  32'hDEADBEEF);
        @(negedge CLK); dma_req = 1'b0; #1;
        chk1 ("dr_gnt_off", dma_gnt, 1'b0);
        @(posedge CLK); #1;
        chk1 ("dr_rvalid_pulse", dma_rvalid, 1'b0);
        chk32("dr_rdata_hold",   dma_rdata,  32'hDEADBEEF);

        // Starvation: pipeline load held, DMA write addr 7 refused 4 cycles, then forced
        @(negedge CLK); MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'd5;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd7; dma_wdata = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1 ("sv_gnt",   dma_gnt,   1'b0);
            chk1 ("sv_stall", StallM,    1'b0);
            chk32("sv_rd",    ReadDataM, 32'hDEADBEEF);
            chk32("sv_addr",  mem_addr,  32'd5);
            @(negedge CLK);
        end
        #1;
        chk1 ("fc_stall", StallM,    1'b1);
        chk1 ("fc_gnt",   dma_gnt,   1'b1);
        chk32("fc_addr",  mem_addr,  32'd7);
        chk1 ("fc_we",    mem_we,    1'b1);
        chk32("fc_wdata", mem_wdata, 32'h1234);
        chk32("fc_rd",    ReadDataM, 32'h0);
        @(negedge CLK); dma_req = 1'b0; #1;
        chk1 ("nm_stall", StallM,    1'b0);
        chk1 ("nm_gnt",   dma_gnt,   1'b0);
        chk32("nm_rd",    ReadDataM, 32'hDEADBEEF);
        @(negedge CLK); ALUOutM = 32'd7; #1;
        chk32("dma_wr_ld", ReadDataM, 32'h1234);

        // Out-of-range pipeline store, sticky flag, clear versus new bad access
        @(negedge CLK); MemWriteM = 1'b1; ALUOutM = 32'd64; WriteDataM = 32'hCAFE; #1;
        chk1 ("oor_we",     mem_we,   1'b0);
        chk1 ("oor_err_pre", addr_err, 1'b0);
        @(posedge CLK); #1;
        chk1 ("oor_err", addr_err, 1'b1);
        @(negedge CLK); MemReqM = 1'b0; MemWriteM = 1'b0;
        @(posedge CLK); #1;
        chk1 ("err_sticky", addr_err, 1'b1);
        @(negedge CLK); err_clr = 1'b1; MemReqM = 1'b1; ALUOutM = 32'd100; #1;
        chk32("oor_rd", ReadDataM, 32'h0);
        @(posedge CLK); #1;
        chk1 ("err_set_wins", addr_err, 1'b1);
        @(negedge CLK); MemReqM = 1'b0;
        @(posedge CLK); #1;
        chk1 ("err_cleared", addr_err, 1'b0);

        // Out-of-range DMA read returns zero and flags the error
        @(negedge CLK); err_clr = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd70; #1;
        chk1 ("dor_gnt", dma_gnt, 1'b1);
        chk1 ("dor_we",  mem_we,  1'b0);
        @(posedge CLK); #1;
        chk1 ("dor_rvalid", dma_rvalid, 1'b1);
        chk32("dor_rdata",  dma_rdata,  32'h0);
        chk1 ("dor_err",    addr_err,   1'b1);

        // Asynchronous reset drops a pending dma_rvalid immediately
        @(negedge CLK); dma_addr = 32'd5; err_clr = 1'b1;
        @(posedge CLK); #1;
        chk1 ("ar_rvalid_pre", dma_rvalid, 1'b1);
        chk1 ("ar_err_clr",    addr_err,   1'b0);
        #1 rst = 1'b1; #1;
        chk1 ("ar_rvalid", dma_rvalid, 1'b0);
        chk32("ar_rdata",  dma_rdata,  32'h0);
        @(negedge CLK); rst = 1'b0; dma_req = 1'b0; err_clr = 1'b0;

        // Asynchronous reset in FORCE returns to NORMAL and restarts the wait count
        @(negedge CLK); MemReqM = 1'b1; MemWriteM = 1'b0; ALUOutM = 32'd5;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd5;
        repeat (4) @(negedge CLK);
        #1;
        chk1 ("rf_stall_pre", StallM,  1'b1);
        chk1 ("rf_gnt_pre",   dma_gnt, 1'b1);
        #1 rst = 1'b1; #1;
        chk1 ("rf_stall", StallM,    1'b0);
        chk1 ("rf_gnt",   dma_gnt,   1'b0);
        chk32("rf_rd",    ReadDataM, 32'hDEADBEEF);
        @(posedge CLK); #1;
        chk1 ("rf_rvalid", dma_rvalid, 1'b0);
        @(negedge CLK); rst = 1'b0; #1;
        chk1 ("rc_gnt0", dma_gnt, 1'b0);
        repeat (3) @(negedge CLK);
        #1;
        chk1 ("rc_gnt3",   dma_gnt, 1'b0);
        chk1 ("rc_stall3", StallM,  1'b0);
        @(negedge CLK); #1;
        chk1 ("rc_gnt4",   dma_gnt, 1'b1);
        chk1 ("rc_stall4", StallM,  1'b1);

        @(negedge CLK); MemReqM = 1'b0; dma_req = 1'b0;
        @(posedge CLK); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
